// File: rtl/bootram_bus_bridge_if.sv
// PicoRV32 native memory bus as seen by a single memory slave.
// The master modport is the CPU/decoder side and the slave modport is the memory side.
interface bootram_bus_bridge_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/bootram_bus_bridge.sv
// 32-bit PicoRV32 bus to 8-bit single-port boot RAM bridge.
// Each word access is split into four byte cycles, and each byte cycle has 1-cycle read latency.
module bootram_bus_bridge #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   resetn,
    bootram_bus_bridge_if.slave    bus,
    output logic [ADDR_WIDTH-1:0]  ram_ad,
    output logic [7:0]             ram_din,
    output logic                   ram_ce,
    output logic                   ram_wre,
    input  logic [7:0]             ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RLAST,
        WRITE,
        DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-3:0] word;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            lane;
    logic                  cap;
    logic [23:0]           rbuf;
    logic [7:0]            lane_byte;
    logic                  lane_strb;

    always_comb begin
        lane_byte = wdata_q[7:0];
        lane_strb = wstrb_q[0];
        case (lane)
            2'd1: begin
                lane_byte = wdata_q[15:8];
                lane_strb = wstrb_q[1];
            end
            2'd2: begin
                lane_byte = wdata_q[23:16];
                lane_strb = wstrb_q[2];
            end
            2'd3: begin
                lane_byte = wdata_q[31:24];
                lane_strb = wstrb_q[3];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            word          <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            lane          <= '0;
            cap           <= 1'b0;
            rbuf          <= '0;
            ram_ad        <= '0;
            ram_din       <= '0;
            ram_ce        <= 1'b0;
            ram_wre       <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.mem_ready <= 1'b0;
                    if (bus.mem_valid) begin
                        word    <= bus.mem_addr[ADDR_WIDTH-1:2];
                        wdata_q <= bus.mem_wdata;
                        wstrb_q <= bus.mem_wstrb;
                        ram_ad  <= {bus.mem_addr[ADDR_WIDTH-1:2], 2'd0};
                        ram_din <= bus.mem_wdata[7:0];
                        ram_ce  <= 1'b1;
                        ram_wre <= bus.mem_wstrb[0];
                        lane    <= 2'd1;
                        state   <= (bus.mem_wstrb == 4'b0000) ? READ : WRITE;
                    end
                end
                READ: begin
                    ram_ad <= {word, lane};
                    ram_ce <= 1'b1;
                    lane   <= lane + 2'd1;
                    // RAM data lags the address by one edge, so lane N is captured two edges after it was issued.
                    if (lane == 2'd2) begin
                        rbuf[7:0] <= ram_dout;
                    end else if (lane == 2'd3) begin
                        rbuf[15:8] <= ram_dout;
                        state      <= RLAST;
                    end
                end
                RLAST: begin
                    ram_ce      <= 1'b0;
                    rbuf[23:16] <= ram_dout;
                    cap         <= 1'b1;
                    lane        <= 2'd0;
                    state       <= DONE;
                end
                WRITE: begin
                    // Lane counter wraps to 0 after lane 3 has been issued; that edge closes the write.
                    if (lane == 2'd0) begin
                        ram_ce        <= 1'b0;
                        ram_wre       <= 1'b0;
                        bus.mem_ready <= 1'b1;
                        state         <= DONE;
                    end else begin
                        ram_ad  <= {word, lane};
                        ram_din <= lane_byte;
                        ram_ce  <= lane_strb;
                        ram_wre <= lane_strb;
                        lane    <= lane + 2'd1;
                    end
                end
                DONE: begin
                    // Reads spend one extra cycle here collecting the last byte before raising ready.
                    if (cap) begin
                        bus.mem_rdata <= {ram_dout, rbuf};
                        bus.mem_ready <= 1'b1;
                        cap           <= 1'b0;
                    end else begin
                        bus.mem_ready <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bootram_bus_bridge.sv
// Scoreboard testbench for bootram_bus_bridge, using a behavioural 2Kx8 boot RAM model.
// Expected read data is queued at issue and compared when the DUT raises mem_ready.
module tb_bootram_bus_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [10:0] ram_ad;
    logic [7:0]  ram_din;
    logic        ram_ce;
    logic        ram_wre;
    logic [7:0]  ram_dout = 8'h00;

    bootram_bus_bridge_if bus();

    bootram_bus_bridge #(.ADDR_WIDTH(11)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .ram_ad   (ram_ad),
        .ram_din  (ram_din),
        .ram_ce   (ram_ce),
        .ram_wre  (ram_wre),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Boot RAM model: single port, write-through, one-cycle read latency.
    logic [7:0] ram [0:2047] = '{0: 8'h6F, 1: 8'h13, 2: 8'h13, 3: 8'h13, default: 8'h00};

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) begin
                ram[ram_ad] <= ram_din;
                ram_dout    <= ram_din;
            end else begin
                ram_dout <= ram[ram_ad];
            end
        end
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          ready_cnt = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_rd = 32'h0;
    logic        prev_ready = 1'b0;
    logic [10:0] ad_log  [0:7];
    logic        wre_log [0:7];
    logic        ce_log  [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must be a single cycle and must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_ready = 1'b0;
        end else begin
            if (bus.mem_ready) begin
                ready_cnt++;
                chk("ready_pulse_width", {31'b0, prev_ready}, 32'h0);
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: got rdata %h expected no ready", bus.mem_rdata);
                end else begin
                    chk("sb_rdata", bus.mem_rdata, sb_q.pop_front());
                end
            end
            prev_ready = bus.mem_ready;
        end
    end

    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rd, output int lat);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        if (wstrb == 4'b0000) last_rd = exp_rd;
        sb_q.push_back(last_rd);
        for (int i = 0; i < 8; i++) begin
            ad_log[i] = '0; wre_log[i] = 1'b0; ce_log[i] = 1'b0;
        end
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        ad_log[0] = ram_ad; wre_log[0] = ram_wre; ce_log[0] = ram_ce;
        lat = 0;
        while (!bus.mem_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat < 8) begin
                ad_log[lat] = ram_ad; wre_log[lat] = ram_wre; ce_log[lat] = ram_ce;
            end
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pack5(input logic b0, input logic b1, input logic b2,
                                          input logic b3, input logic b4);
        return {27'b0, b4, b3, b2, b1, b0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [14:0] rdy_bits;
        logic [14:0] ce_bits;

        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        chk("rst_ram_ce", {31'b0, ram_ce}, 32'h0);
        chk("rst_ram_wre", {31'b0, ram_wre}, 32'h0);
        chk("rst_ram_ad", {21'b0, ram_ad}, 32'h0);
        chk("rst_ram_din", {24'b0, ram_din}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Boot image read
        do_txn(32'h0000_0000, 32'h0, 4'b0000, 32'h1313_136F, lat);
        chk("rd0_latency", lat, 5);
        for (int k = 0; k < 4; k++) chk("rd0_ad_seq", {21'b0, ad_log[k]}, k);
        chk("rd0_ce_pattern", pack5(ce_log[0], ce_log[1], ce_log[2], ce_log[3], ce_log[4]), 32'h0F);

        // Full-word write; mem_rdata must keep the previous read value
        do_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, lat);
        chk("wr_full_latency", lat, 4);
        chk("wr_full_wre", pack5(wre_log[0], wre_log[1], wre_log[2], wre_log[3], wre_log[4]), 32'h0F);
        do_txn(32'h0000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, lat);
        chk("rd10_latency", lat, 5);

        // Partial write, lanes 0 and 2
        do_txn(32'h0000_0010, 32'h1122_3344, 4'b0101, 32'h0, lat);
        chk("wr_part_latency", lat, 4);
        chk("wr_part_wre", pack5(wre_log[0], wre_log[1], wre_log[2], wre_log[3], wre_log[4]), 32'h05);
        chk("wr_part_ad0", {21'b0, ad_log[0]}, 32'h10);
        chk("wr_part_ad2", {21'b0, ad_log[2]}, 32'h12);
        do_txn(32'h0000_0010, 32'h0, 4'b0000, 32'hDE22_BE44, lat);

        // High and low address bits ignored
        do_txn(32'h0000_0813, 32'h0, 4'b0000, 32'hDE22_BE44, lat);
        for (int k = 0; k < 4; k++) chk("alias_ad_seq", {21'b0, ad_log[k]}, 32'h10 + k);

        // mem_valid held across ready: second read starts only after DONE
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0010;
        bus.mem_wstrb = 4'b0000;
        sb_q.push_back(32'hDE22_BE44);
        sb_q.push_back(32'hDE22_BE44);
        last_rd = 32'hDE22_BE44;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            rdy_bits[e] = bus.mem_ready;
            ce_bits[e]  = ram_ce;
            if (e == 8) bus.mem_valid = 1'b0;
        end
        chk("hold_ready_edges", {17'b0, rdy_bits}, 32'h1020);
        chk("hold_ce_edges", {17'b0, ce_bits}, 32'h078F);

        // Reset between E2 and E3 of a read
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0010;
        bus.mem_wdata = 32'h0000_00A5;
        bus.mem_wstrb = 4'b0000;
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, bus.mem_ready}, 32'h0);
        chk("midrst_rdata", bus.mem_rdata, 32'h0);
        chk("midrst_ram_ce", {31'b0, ram_ce}, 32'h0);
        chk("midrst_ram_ad", {21'b0, ram_ad}, 32'h0);
        chk("midrst_ram_din", {24'b0, ram_din}, 32'h0);
        last_rd = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        do_txn(32'h0000_0000, 32'h0, 4'b0000, 32'h1313_136F, lat);
        chk("post_rst_latency", lat, 5);

        repeat (10) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("ready_total", ready_cnt, 9);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
